// File: rtl/link_receiver_pkg.sv
// Shared types and constants for the link receiver and its transmit-side framer.
// Frame layout is {seq, payload, crc8}; the CRC covers {seq, payload}.
package link_receiver_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int DEF_SEQ_WIDTH = 4;
  localparam int DEF_PACKET_WIDTH = 64;

  typedef struct packed {
    logic [DEF_SEQ_WIDTH-1:0]    seq;
    logic [DEF_PACKET_WIDTH-1:0] payload;
    logic [7:0]                  crc;
  } link_frame_t;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    NACK,
    ERROR
  } rx_state_t;

endpackage

// File: rtl/link_receiver_if.sv
// Link-side frame input, downstream delivery handshake and ack/nack feedback.
// The sender/consumer side uses master; the receiver uses slave.
interface link_receiver_if #(
  parameter int packet_width = 64,
  parameter int seq_width = 4
);

  logic                              link_valid;
  logic [seq_width+packet_width+7:0] link_frame;
  logic                              out_valid;
  logic [packet_width-1:0]           out_packet;
  logic                              out_ready;
  logic                              ack;
  logic [seq_width-1:0]              ack_count;
  logic                              nack;

  modport master (
    output link_valid, link_frame, out_ready,
    input  out_valid, out_packet, ack, ack_count, nack
  );

  modport slave (
    input  link_valid, link_frame, out_ready,
    output out_valid, out_packet, ack, ack_count, nack
  );

endinterface

// File: rtl/link_receiver_crc8.sv
// Combinational CRC-8 (init 0x00, no reflection, MSB first) over an arbitrary-width word.
// Shared by the receiver check and the transmit-side framer.
module crc8
  import link_receiver_pkg::*;
#(
  parameter int data_width = 68
) (
  input  logic [data_width-1:0] data,
  output logic [7:0]            crc
);

  always_comb begin
    logic [7:0] c;
    c = 8'h00;
    for (int i = data_width - 1; i >= 0; i--) begin
      if (c[7] ^ data[i]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    crc = c;
  end

endmodule

// File: rtl/link_receiver.sv
// Go-back-N link receiver: checks CRC and sequence, delivers in order through a
// one-entry holding register, and returns coalesced acks plus nacks on error.
module link_receiver
  import link_receiver_pkg::*;
#(
  parameter int packet_width = 64,
  parameter int seq_width = 4,
  parameter int ack_threshold = 4,
  parameter int ack_timeout = 32,
  parameter int nack_timeout = 64
) (
  input logic            clk,
  input logic            reset,
  link_receiver_if.slave bus
);

  localparam int frame_width = seq_width + packet_width + 8;
  localparam int at_w = (ack_timeout > 2) ? $clog2(ack_timeout) : 1;
  localparam int nt_w = (nack_timeout > 2) ? $clog2(nack_timeout) : 1;
  localparam logic [at_w-1:0] ack_limit = at_w'(ack_timeout - 1);
  localparam logic [nt_w-1:0] nack_limit = nt_w'(nack_timeout - 1);
  localparam logic [at_w-1:0] at_one = {{(at_w-1){1'b0}}, 1'b1};
  localparam logic [nt_w-1:0] nt_one = {{(nt_w-1){1'b0}}, 1'b1};
  localparam logic [seq_width-1:0] seq_one = {{(seq_width-1){1'b0}}, 1'b1};
  localparam logic [seq_width-1:0] pending_max = '1;

  rx_state_t               state_reg, state_next;
  logic [seq_width-1:0]    expected_seq_reg, expected_seq_next;
  logic [seq_width-1:0]    pending_reg, pending_next;
  logic [at_w-1:0]         ack_timer_reg, ack_timer_next;
  logic [nt_w-1:0]         nack_timer_reg, nack_timer_next;
  logic                    out_valid_reg, out_valid_next;
  logic [packet_width-1:0] out_packet_reg, out_packet_next;
  logic                    ack_reg, ack_next;
  logic [seq_width-1:0]    ack_count_reg, ack_count_next;
  logic                    nack_reg, nack_next;

  logic [seq_width-1:0]    rx_seq;
  logic [packet_width-1:0] rx_payload;
  logic [7:0]              rx_crc;
  logic [7:0]              calc_crc;
  logic                    good;
  logic                    room;
  logic                    accept;
  logic                    ack_due;

  assign rx_seq     = bus.link_frame[frame_width-1 -: seq_width];
  assign rx_payload = bus.link_frame[packet_width+7:8];
  assign rx_crc     = bus.link_frame[7:0];

  crc8 #(.data_width(seq_width + packet_width)) u_crc8 (
    .data (bus.link_frame[frame_width-1:8]),
    .crc  (calc_crc)
  );

  assign good = bus.link_valid && (calc_crc == rx_crc) && (rx_seq == expected_seq_reg);
  // The holding register can take a new payload if empty or emptied on this edge.
  assign room = !out_valid_reg || bus.out_ready;
  assign ack_due = (int'(pending_reg) >= ack_threshold) || (pending_reg == pending_max) ||
                   ((pending_reg != '0) && (ack_timer_reg == ack_limit));

  always_comb begin
    state_next        = state_reg;
    expected_seq_next = expected_seq_reg;
    pending_next      = pending_reg;
    ack_timer_next    = (ack_timer_reg == ack_limit) ? ack_timer_reg : ack_timer_reg + at_one;
    nack_timer_next   = nack_timer_reg;
    out_valid_next    = out_valid_reg && !bus.out_ready;
    out_packet_next   = out_packet_reg;
    ack_next          = 1'b0;
    ack_count_next    = ack_count_reg;
    nack_next         = 1'b0;
    accept            = 1'b0;

    case (state_reg)
      RUN: begin
        if (bus.link_valid && !(good && room)) begin
          // Error frame: pending acks go out first so the sender's replay starts clean.
          state_next = (pending_reg != '0) ? FLUSH : NACK;
        end else begin
          accept = good;
          if (ack_due) begin
            ack_next       = 1'b1;
            ack_count_next = pending_reg;
            pending_next   = accept ? seq_one : '0;
            ack_timer_next = '0;
          end else if (accept) begin
            pending_next   = pending_reg + seq_one;
            ack_timer_next = '0;
          end
        end
      end
      FLUSH: begin
        ack_next       = 1'b1;
        ack_count_next = pending_reg;
        pending_next   = '0;
        state_next     = NACK;
      end
      NACK: begin
        nack_next       = 1'b1;
        nack_timer_next = '0;
        state_next      = ERROR;
      end
      ERROR: begin
        if (good && room) begin
          accept         = 1'b1;
          pending_next   = pending_reg + seq_one;
          ack_timer_next = '0;
          state_next     = RUN;
        end else if (nack_timer_reg == nack_limit) begin
          nack_next       = 1'b1;
          nack_timer_next = '0;
        end else begin
          nack_timer_next = nack_timer_reg + nt_one;
        end
      end
      default: state_next = RUN;
    endcase

    if (accept) begin
      expected_seq_next = expected_seq_reg + seq_one;
      out_valid_next    = 1'b1;
      out_packet_next   = rx_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= RUN;
      expected_seq_reg <= '0;
      pending_reg      <= '0;
      ack_timer_reg    <= '0;
      nack_timer_reg   <= '0;
      out_valid_reg    <= 1'b0;
      out_packet_reg   <= '0;
      ack_reg          <= 1'b0;
      ack_count_reg    <= '0;
      nack_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      expected_seq_reg <= expected_seq_next;
      pending_reg      <= pending_next;
      ack_timer_reg    <= ack_timer_next;
      nack_timer_reg   <= nack_timer_next;
      out_valid_reg    <= out_valid_next;
      out_packet_reg   <= out_packet_next;
      ack_reg          <= ack_next;
      ack_count_reg    <= ack_count_next;
      nack_reg         <= nack_next;
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_packet = out_packet_reg;
  assign bus.ack        = ack_reg;
  assign bus.ack_count  = ack_count_reg;
  assign bus.nack       = nack_reg;

endmodule

// File: tb/tb_link_receiver.sv
// Directed bench for link_receiver: a vector table for reset, gap and in-order
// delivery, then hand sequences for timeouts, CRC error, overrun and wrap/reset.
module tb_link_receiver;
  import link_receiver_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  link_receiver_if #(.packet_width(64), .seq_width(4)) bus ();

  link_receiver #(
    .packet_width(64), .seq_width(4), .ack_threshold(4),
    .ack_timeout(32), .nack_timeout(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       v;
    logic [3:0] s;
    logic [7:0] pk;
    logic       bad;
    logic       rdy;
    logic       e_ov;
    logic [7:0] e_pk;
    logic       e_ack;
    logic [3:0] e_cnt;
    logic       e_nack;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [63:0] pay(input logic [7:0] k);
    return {8{k ^ 8'h5A}};
  endfunction

  // Long division of the message augmented with eight zero bits.
  function automatic logic [7:0] crc_model(input logic [67:0] msg);
    logic [75:0] aug;
    logic [7:0]  rem;
    logic        top;
    aug = {msg, 8'h00};
    rem = 8'h00;
    for (int i = 75; i >= 0; i--) begin
      top = rem[7];
      rem = {rem[6:0], aug[i]};
      if (top) rem = rem ^ 8'h07;
    end
    return rem;
  endfunction

  task automatic cmp(input string name, input string sig, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s %s: got %h expected %h", name, sig, act, exp);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic v, input logic [3:0] s,
                      input logic [7:0] pk, input logic bad, input logic rdy,
                      input logic e_ov, input logic [7:0] e_pk, input logic e_ack,
                      input logic [3:0] e_cnt, input logic e_nack);
    link_frame_t f;
    f.seq     = s;
    f.payload = pay(pk);
    f.crc     = crc_model({s, pay(pk)}) ^ (bad ? 8'hFF : 8'h00);
    reset          = rst;
    bus.link_valid = v;
    bus.link_frame = f;
    bus.out_ready  = rdy;
    @(posedge clk);
    #1;
    cmp(name, "out_valid", 64'(bus.out_valid), 64'(e_ov));
    if (rst) cmp(name, "out_packet", bus.out_packet, 64'h0);
    else if (e_ov) cmp(name, "out_packet", bus.out_packet, pay(e_pk));
    cmp(name, "ack", 64'(bus.ack), 64'(e_ack));
    if (e_ack || rst) cmp(name, "ack_count", 64'(bus.ack_count), 64'(e_cnt));
    cmp(name, "nack", 64'(bus.nack), 64'(e_nack));
    $display("%s: v=%0d seq=%0d ov=%0d ack=%0d cnt=%0d nack=%0d", name, v, s,
             bus.out_valid, bus.ack, bus.ack_count, bus.nack);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.link_valid = 1'b0;
    bus.link_frame = '0;
    bus.out_ready = 1'b1;

    //            name        rst   v     s     pk     bad   rdy   e_ov  e_pk   ack   cnt   nack
    tbl[0]  = '{"rst_a",    1'b1, 1'b1, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{"gap_s0",   1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{"gap_s2",   1'b0, 1'b1, 4'd2, 8'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{"gap_ack",  1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd1, 1'b0};
    tbl[4]  = '{"gap_nack", 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b1};
    tbl[5]  = '{"rst_err",  1'b1, 1'b1, 4'd3, 8'd3, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{"ino_s0",   1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0};
    tbl[7]  = '{"ino_s1",   1'b0, 1'b1, 4'd1, 8'd1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 4'd0, 1'b0};
    tbl[8]  = '{"ino_s2",   1'b0, 1'b1, 4'd2, 8'd2, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 4'd0, 1'b0};
    tbl[9]  = '{"ino_s3",   1'b0, 1'b1, 4'd3, 8'd3, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 4'd0, 1'b0};
    tbl[10] = '{"ino_s4",   1'b0, 1'b1, 4'd4, 8'd4, 1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 4'd4, 1'b0};
    tbl[11] = '{"ino_s5",   1'b0, 1'b1, 4'd5, 8'd5, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 4'd0, 1'b0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].name, tbl[i].rst, tbl[i].v, tbl[i].s, tbl[i].pk, tbl[i].bad, tbl[i].rdy,
           tbl[i].e_ov, tbl[i].e_pk, tbl[i].e_ack, tbl[i].e_cnt, tbl[i].e_nack);
    end

    // Two acks still pending after seq 5: flushed on the 32nd idle cycle.
    for (int i = 1; i <= 32; i++) begin
      step("ack_timeout", 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0,
           (i == 32), 4'd2, 1'b0);
    end

    // CRC error on seq 2, replay 2..4, then a bad frame proves the FSM is back in RUN.
    step("crc_rst",   1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    step("crc_s0",    1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
    step("crc_s1",    1'b0, 1'b1, 4'd1, 8'd1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 4'd0, 1'b0);
    step("crc_bad2",  1'b0, 1'b1, 4'd2, 8'd2, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    step("crc_ack",   1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd2, 1'b0);
    step("crc_nack",  1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b1);
    step("crc_rp2",   1'b0, 1'b1, 4'd2, 8'd2, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 4'd0, 1'b0);
    step("crc_rp3",   1'b0, 1'b1, 4'd3, 8'd3, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 4'd0, 1'b0);
    step("crc_rp4",   1'b0, 1'b1, 4'd4, 8'd4, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0, 4'd0, 1'b0);
    step("run_bad5",  1'b0, 1'b1, 4'd5, 8'd5, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    step("run_ack",   1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd3, 1'b0);
    step("run_nack",  1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b1);

    // In ERROR with no frames, nack repeats exactly 64 cycles later.
    for (int i = 1; i <= 64; i++) begin
      step("nack_timeout", 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0,
           (i == 64));
    end
    step("err_bad",   1'b0, 1'b1, 4'd5, 8'd5, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    step("err_good",  1'b0, 1'b1, 4'd5, 8'd5, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 4'd0, 1'b0);

    // Overrun: seq 0 stalls in the holding register, seq 1 is dropped.
    step("ovr_rst",   1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    step("ovr_s0",    1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
    step("ovr_s1",    1'b0, 1'b1, 4'd1, 8'd1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, 1'b0);
    step("ovr_ack",   1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 4'd1, 1'b0);
    step("ovr_nack",  1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0, 1'b1);
    step("ovr_drain", 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    step("ovr_rp1",   1'b0, 1'b1, 4'd1, 8'd1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 4'd0, 1'b0);
    step("ovr_idle",  1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);

    // 20 frames wrap the sequence number; threshold acks every fourth edge.
    step("wrap_rst",  1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step("wrap", 1'b0, 1'b1, 4'(i), 8'(i), 1'b0, 1'b1, 1'b1, 8'(i),
           (i >= 4) && (i % 4 == 0), 4'd4, 1'b0);
    end
    step("wrap_midrst", 1'b1, 1'b1, 4'd4, 8'd20, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step("post_rst_idle", 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
    end
    step("post_rst_s0", 1'b0, 1'b1, 4'd0, 8'd30, 1'b0, 1'b1, 1'b1, 8'd30, 1'b0, 4'd0, 1'b0);
    step("post_rst_s1", 1'b0, 1'b1, 4'd1, 8'd31, 1'b0, 1'b1, 1'b1, 8'd31, 1'b0, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
